line_burst_adaptor: RTL

Memory-side responder for the cache's line-wide downstream interface. Accepts one 256-bit line read or write, converts it into a 4-beat, 64-bit burst on the physical-memory port, and returns a single-cycle line response. Sits between the last-level cache core and main memory.

---
 rtl/line_adaptor_pkg.sv | 34 +++
 rtl/line_beat_buffer.sv | 46 ++++
 rtl/line_burst_adaptor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/line_adaptor_pkg.sv
// line_adaptor_pkg
// Shared types and constants for the line-to-burst memory adaptor.
//   S_OFFSET   : line offset bits (line address has these bits cleared)
//   S_LINE     : line width in bits
//   S_BEAT     : burst beat width in bits
//   NUM_BEATS  : beats per line
//   beat_idx_t : beat counter / slice index type
//   state_e    : adaptor FSM states
package line_adaptor_pkg;

    localparam int S_OFFSET  = 5;
    localparam int S_LINE    = 256;
    localparam int S_BEAT    = 64;
    localparam int NUM_BEATS = S_LINE / S_BEAT;
    localparam int BEAT_W    = $clog2(NUM_BEATS);

    typedef logic [BEAT_W-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Clear the offset bits to form the line-aligned address.
    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        a[S_OFFSET-1:0] = '0;
        return a;
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// line_beat_buffer
// One cache line of storage, viewed as NUM_BEATS beat slices.
//   clk, rst_n  : clock, synchronous active-low reset (clears the line)
//   line_load   : load the whole line from line_in (takes priority)
//   line_in     : full line input
//   beat_load   : load slice beat_idx from beat_in
//   beat_idx    : slice written by beat_load
//   beat_in     : beat data input
//   rd_idx      : slice selected onto beat_out
//   line_out    : full stored line
//   beat_out    : stored slice rd_idx
module line_beat_buffer
    import line_adaptor_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              line_load,
    input  logic [NUM_BEATS-1:0][S_BEAT-1:0]  line_in,
    input  logic                              beat_load,
    input  beat_idx_t                         beat_idx,
    input  logic [S_BEAT-1:0]                 beat_in,
    input  beat_idx_t                         rd_idx,
    output logic [NUM_BEATS-1:0][S_BEAT-1:0]  line_out,
    output logic [S_BEAT-1:0]                 beat_out
);

    logic [NUM_BEATS-1:0][S_BEAT-1:0] buf_q, buf_d;

    always_comb begin
        buf_d = buf_q;
        if (line_load) begin
            buf_d = line_in;
        end else if (beat_load) begin
            buf_d[beat_idx] = beat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) buf_q <= '0;
        else        buf_q <= buf_d;
    end

    assign line_out = buf_q;
    assign beat_out = buf_q[rd_idx];

endmodule

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
// Turns one held 256-bit line read/write from the cache into a 4-beat 64-bit
// burst on the memory port, then pulses line_resp for one cycle.
//   clk, rst_n                 : clock, synchronous active-low reset
//   line_read / line_write     : line request (held until line_resp; write wins)
//   line_address / line_wdata  : request address / write line
//   line_resp / line_rdata     : completion pulse / last assembled read line
//   mem_read / mem_write       : registered burst requests
//   mem_address / mem_wdata    : line-aligned burst address / current write beat
//   mem_rdata / mem_resp       : read beat / beat handshake from memory
module line_burst_adaptor
    import line_adaptor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_address,
    input  logic [S_LINE-1:0] line_wdata,
    output logic              line_resp,
    output logic [S_LINE-1:0] line_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [S_BEAT-1:0] mem_wdata,
    input  logic [S_BEAT-1:0] mem_rdata,
    input  logic              mem_resp
);

    state_e            state_q, state_d;
    beat_idx_t         beat_q, beat_d;
    logic [31:0]       mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              line_resp_q, line_resp_d;
    logic [S_BEAT-1:0] mem_wdata_q, mem_wdata_d;

    logic              wbuf_line_load;
    logic              rbuf_beat_load;
    beat_idx_t         wbuf_rd_idx;
    logic [S_BEAT-1:0] wbuf_beat;
    logic [S_BEAT-1:0] rbuf_beat_unused;
    logic [S_LINE-1:0] wbuf_line_unused;
    logic              last_beat;

    assign last_beat = (beat_q == beat_idx_t'(NUM_BEATS - 1));
    // mem_wdata is registered, so the write buffer is read one beat ahead.
    assign wbuf_rd_idx = beat_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        mem_address_d  = mem_address_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_wdata_d    = mem_wdata_q;
        line_resp_d    = 1'b0;
        wbuf_line_load = 1'b0;
        rbuf_beat_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_write) begin
                    state_d        = WRITE;
                    beat_d         = '0;
                    mem_address_d  = align_addr(line_address);
                    mem_write_d    = 1'b1;
                    // Buffer loads on the same edge, so beat 0 comes straight from the input.
                    mem_wdata_d    = line_wdata[S_BEAT-1:0];
                    wbuf_line_load = 1'b1;
                end else if (line_read) begin
                    state_d       = READ;
                    beat_d        = '0;
                    mem_address_d = align_addr(line_address);
                    mem_read_d    = 1'b1;
                end
            end
            READ: begin
                if (mem_resp) begin
                    rbuf_beat_load = 1'b1;
                    if (last_beat) begin
                        state_d     = DONE;
                        beat_d      = '0;
                        mem_read_d  = 1'b0;
                        line_resp_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_resp) begin
                    if (last_beat) begin
                        state_d     = DONE;
                        beat_d      = '0;
                        mem_write_d = 1'b0;
                        mem_wdata_d = '0;
                        line_resp_d = 1'b1;
                    end else begin
                        beat_d      = beat_q + 1'b1;
                        mem_wdata_d = wbuf_beat;
                    end
                end
            end
            DONE: begin
                // Requests still held here belong to the finished transaction.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
            line_resp_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
            line_resp_q   <= line_resp_d;
        end
    end

    // Separate buffers so a write never disturbs the line visible on line_rdata.
    line_beat_buffer u_rbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_load (1'b0),
        .line_in   ('0),
        .beat_load (rbuf_beat_load),
        .beat_idx  (beat_q),
        .beat_in   (mem_rdata),
        .rd_idx    ('0),
        .line_out  (line_rdata),
        .beat_out  (rbuf_beat_unused)
    );

    line_beat_buffer u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_load (wbuf_line_load),
        .line_in   (line_wdata),
        .beat_load (1'b0),
        .beat_idx  ('0),
        .beat_in   ('0),
        .rd_idx    (wbuf_rd_idx),
        .line_out  (wbuf_line_unused),
        .beat_out  (wbuf_beat)
    );

    assign line_resp   = line_resp_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
